mem_arbiter: RTL and testbench

- Round-robin arbiter that shares the single RAM port among NREQ cache requesters, e.g. icache/dcache of core 0 and core 1.
- Sits between the multicore processor's cache memory ports and the RAM-side memory signals. The existing tbCTRL mux stays downstream of this block.
- Serialises whole word accesses and holds the chosen requester granted until the RAM reports ACCESS.

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared CPU-side types: RAM handshake state and memory arbiter FSM state.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic {
      ARB = 1'b0,
      OWN = 1'b1
   } arbstate_t;

   localparam int STAT_W = 16;

   // Explicit wrap so that non-power-of-two requester counts work.
   function automatic int rr_next(input int cur, input int n);
      return (cur >= n - 1) ? 0 : cur + 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first active index at or after rr_ptr, wrapping mod NREQ.
// Zero latency; valid is low when no input is active.
module rr_pick
   import cpu_types_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] act,
   input  logic [PW-1:0]   rr_ptr,
   output logic            valid,
   output logic [PW-1:0]   idx
);

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      // Descending scan so the smallest offset from rr_ptr is written last and wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         int c;
         c = int'(rr_ptr) + k;
         if (c >= NREQ) c = c - NREQ;
         if (act[c]) begin
            valid = 1'b1;
            idx   = PW'(c);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ cache requesters; holds a grant until ACCESS.
// Optional per-requester grant and error counters when MEM_ARB_STATS_EN is defined.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [NREQ-1:0]          req_ren,
   input  logic [NREQ-1:0]          req_wen,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_store,
   output logic [NREQ-1:0]          req_wait,
   output logic [DATA_W-1:0]        req_load,
   output logic                     ram_ren,
   output logic                     ram_wen,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [DATA_W-1:0]        ram_store,
   input  logic [DATA_W-1:0]        ram_load,
   input  logic [1:0]               ram_state,
   output logic [$clog2(NREQ)-1:0]  grant_id
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [NREQ*STAT_W-1:0]   stat_grants,
   output logic [STAT_W-1:0]        stat_errors
`endif
);

   localparam int PW = $clog2(NREQ);

   arbstate_t        r_state;
   logic [PW-1:0]    r_grant;
   logic [PW-1:0]    r_rr_ptr;

   logic [NREQ-1:0]  w_act;
   logic             w_pick_vld;
   logic [PW-1:0]    w_pick_idx;
   ramstate_t        w_rs;
   logic             w_own;
   logic             w_g_act;
   logic             w_done;

   assign w_act   = req_ren | req_wen;
   assign w_rs    = ramstate_t'(ram_state);
   assign w_own   = (r_state == OWN);
   assign w_g_act = w_act[r_grant];
   assign w_done  = w_own && w_g_act && (w_rs == ACCESS);

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
      .act    (w_act),
      .rr_ptr (r_rr_ptr),
      .valid  (w_pick_vld),
      .idx    (w_pick_idx)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= ARB;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else begin
         case (r_state)
            ARB: begin
               if (w_pick_vld) begin
                  r_grant <= w_pick_idx;
                  r_state <= OWN;
               end
            end
            OWN: begin
               // Abandon leaves the pointer alone so the same requester keeps its turn.
               if (!w_g_act) begin
                  r_state <= ARB;
               end else if (w_rs == ACCESS) begin
                  r_rr_ptr <= PW'(rr_next(int'(r_grant), NREQ));
                  r_state  <= ARB;
               end
            end
            default: r_state <= ARB;
         endcase
      end
   end

   always_comb begin
      ram_ren   = 1'b0;
      ram_wen   = 1'b0;
      ram_addr  = '0;
      ram_store = '0;
      if (w_own) begin
         ram_wen   = req_wen[r_grant];
         ram_ren   = req_ren[r_grant] & ~req_wen[r_grant];
         ram_addr  = req_addr[r_grant*ADDR_W +: ADDR_W];
         ram_store = req_store[r_grant*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      req_wait = w_act;
      if (w_done) req_wait[r_grant] = 1'b0;
   end

   assign req_load = ram_load;
   assign grant_id = r_grant;

`ifdef MEM_ARB_STATS_EN
   logic [NREQ*STAT_W-1:0] r_stat_grants;
   logic [STAT_W-1:0]      r_stat_errors;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_stat_grants <= '0;
         r_stat_errors <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (w_done && (r_grant == PW'(i)) &&
                (r_stat_grants[i*STAT_W +: STAT_W] != {STAT_W{1'b1}}))
               r_stat_grants[i*STAT_W +: STAT_W] <= r_stat_grants[i*STAT_W +: STAT_W] + 1'b1;
         end
         if (w_own && (w_rs == ERROR) && (r_stat_errors != {STAT_W{1'b1}}))
            r_stat_errors <= r_stat_errors + 1'b1;
      end
   end

   assign stat_grants = r_stat_grants;
   assign stat_errors = r_stat_errors;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (NREQ=4, 32-bit address/data).
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int NREQ = 4;

   logic              CLK;
   logic              nRST;
   logic [3:0]        req_ren, req_wen;
   logic [127:0]      req_addr, req_store;
   logic [3:0]        req_wait;
   logic [31:0]       req_load;
   logic              ram_ren, ram_wen;
   logic [31:0]       ram_addr, ram_store, ram_load;
   logic [1:0]        ram_state;
   logic [1:0]        grant_id;
`ifdef MEM_ARB_STATS_EN
   logic [63:0]       stat_grants;
   logic [15:0]       stat_errors;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] addr_tbl [4];
   int order [6];

   mem_arbiter #(.NREQ(4), .ADDR_W(32), .DATA_W(32)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .req_ren   (req_ren),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_store (req_store),
      .req_wait  (req_wait),
      .req_load  (req_load),
      .ram_ren   (ram_ren),
      .ram_wen   (ram_wen),
      .ram_addr  (ram_addr),
      .ram_store (ram_store),
      .ram_load  (ram_load),
      .ram_state (ram_state),
      .grant_id  (grant_id)
`ifdef MEM_ARB_STATS_EN
      ,
      .stat_grants (stat_grants),
      .stat_errors (stat_errors)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      addr_tbl[0] = 32'h1000; addr_tbl[1] = 32'h2000;
      addr_tbl[2] = 32'h3000; addr_tbl[3] = 32'h4000;
      order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0; order[5] = 1;
      for (int i = 0; i < 4; i++) begin
         req_addr[i*32 +: 32]  = addr_tbl[i];
         req_store[i*32 +: 32] = 32'hA0 + i;
      end
      nRST      = 1'b0;
      req_ren   = 4'b0010;
      req_wen   = 4'b0000;
      ram_load  = 32'h0;
      ram_state = FREE;

      // Reset state with requester 1 already asking
      #1;
      chk("rst_ram_ren", ram_ren, 0);
      chk("rst_ram_wen", ram_wen, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_store", ram_store, 0);
      chk("rst_req_wait", req_wait, 4'b0010);
      chk("rst_grant", grant_id, 0);
      step();
      nRST = 1'b1;
      step();
      #1;
      chk("t1_ram_ren", ram_ren, 1);
      chk("t1_ram_addr", ram_addr, 32'h2000);
      chk("t1_grant", grant_id, 1);
      chk("t1_wait_busy", req_wait, 4'b0010);
      ram_state = ACCESS;
      ram_load  = 32'hDEADBEEF;
      #1;
      chk("t1_wait_access", req_wait, 4'b0000);
      chk("t1_load", req_load, 32'hDEADBEEF);
      step();
      ram_state = FREE;
      #1;
      chk("t1_bubble_ren", ram_ren, 0);
      chk("t1_wait_after", req_wait, 4'b0010);
      req_ren = 4'b0000;

      // Fresh reset, then all four read continuously
      nRST = 1'b0;
      #1;
      step();
      nRST    = 1'b1;
      req_ren = 4'b1111;
      for (int n = 0; n < 6; n++) begin
         #1;
         chk($sformatf("t2_bubble%0d", n), ram_ren, 0);
         step();
         ram_state = BUSY;
         #1;
         chk($sformatf("t2_grant%0d", n), grant_id, order[n]);
         chk($sformatf("t2_addr%0d", n), ram_addr, addr_tbl[order[n]]);
         chk($sformatf("t2_ren%0d", n), ram_ren, 1);
         step();
         ram_state = ACCESS;
         #1;
         chk($sformatf("t2_wait%0d", n), req_wait, 4'b1111 & ~(4'b0001 << order[n]));
         step();
         ram_state = FREE;
      end
      req_ren = 4'b0000;

      // Requester 2 writes and reads together: write wins
      req_addr[2*32 +: 32]  = 32'h100;
      req_store[2*32 +: 32] = 32'h55;
      req_ren = 4'b0100;
      req_wen = 4'b0100;
      step();
      #1;
      chk("t3_grant", grant_id, 2);
      chk("t3_wen", ram_wen, 1);
      chk("t3_ren", ram_ren, 0);
      chk("t3_addr", ram_addr, 32'h100);
      chk("t3_store", ram_store, 32'h55);
      ram_state = ACCESS;
      step();
      ram_state = FREE;
      req_ren = 4'b0000;
      req_wen = 4'b0000;

      // Requester 3 abandons; it keeps its turn over requester 0
      req_ren = 4'b1000;
      step();
      #1;
      chk("t4_grant", grant_id, 3);
      chk("t4_ren", ram_ren, 1);
      req_ren = 4'b0000;
      #1;
      chk("t4_ren_drop", ram_ren, 0);
      chk("t4_wait_drop", req_wait, 4'b0000);
      step();
      req_ren = 4'b1001;
      #1;
      chk("t4_arb_ren", ram_ren, 0);
      step();
      #1;
      chk("t4_regrant", grant_id, 3);
      ram_state = ACCESS;
      #1;
      chk("t4_wait_done", req_wait, 4'b0001);
      step();
      ram_state = FREE;
      req_ren = 4'b0000;

      // ERROR cycles are retried until ACCESS
      req_ren = 4'b0010;
      step();
      for (int n = 0; n < 3; n++) begin
         ram_state = ERROR;
         #1;
         chk($sformatf("t5_err_ren%0d", n), ram_ren, 1);
         chk($sformatf("t5_err_wait%0d", n), req_wait, 4'b0010);
         step();
      end
      ram_state = ACCESS;
      #1;
      chk("t5_acc_wait", req_wait, 4'b0000);
      chk("t5_acc_ren", ram_ren, 1);
      step();
      ram_state = FREE;
      #1;
      chk("t5_after_ren", ram_ren, 0);
      chk("t5_after_wait", req_wait, 4'b0010);
      req_ren = 4'b0000;
`ifdef MEM_ARB_STATS_EN
      chk("t5_stat_errors", stat_errors, 3);
      chk("t5_stat_grants1", stat_grants[16 +: 16], 3);
`endif

      // Asynchronous reset mid-access
      req_ren = 4'b0100;
      step();
      #1;
      chk("t6_own_ren", ram_ren, 1);
      chk("t6_own_grant", grant_id, 2);
      req_ren = 4'b0101;
      nRST    = 1'b0;
      #1;
      chk("t6_rst_ren", ram_ren, 0);
      chk("t6_rst_grant", grant_id, 0);
      chk("t6_rst_wait", req_wait, 4'b0101);
      step();
      nRST = 1'b1;
      step();
      #1;
      chk("t6_post_grant", grant_id, 0);
      chk("t6_post_addr", ram_addr, 32'h1000);
      chk("t6_post_ren", ram_ren, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
